// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the async_fifo read-side stream stage.
package async_fifo_pkg;

    localparam int unsigned RD_LATENCY = 1;
    localparam int unsigned BUF_DEPTH  = 2;

    typedef logic [1:0] level_t;

endpackage

// File: rtl/fifo_hold_buf.sv
// Two-entry register FIFO holding prefetched words ahead of the stream port.
module fifo_hold_buf
    import async_fifo_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [Width-1:0] data,
    output level_t           count
);

    logic [Width-1:0] mem [BUF_DEPTH];
    logic             head;
    logic             tail;

    // Storage, pointers and occupancy; flush clears the pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem[i] <= '0;
            end
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= '0;
        end else if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= '0;
        end else begin
            assert (!(push && !pop && count == level_t'(BUF_DEPTH)));
            assert (!(pop && count == '0));
            if (push) begin
                mem[tail] <= push_data;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + level_t'(push) - level_t'(pop);
        end
    end

    assign data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts the async_fifo registered-read port into a full-throughput valid/ready stream.
module fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int unsigned Width    = 8,
    parameter int unsigned BufDepth = BUF_DEPTH
) (
    input  logic             clk_rd,
    input  logic             rst,
    output logic             o_fifo_rd_en,
    input  logic             i_fifo_empty,
    input  logic [Width-1:0] i_fifo_rd_data,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [Width-1:0] o_data,
    input  logic             i_ready,
    output logic [1:0]       o_level
);

    level_t     occ;
    logic       inflight;
    logic       pop;
    logic       land;
    logic [2:0] demand;

    assign pop  = o_valid & i_ready;
    assign land = inflight & ~i_flush;

    // Slots already committed after this cycle's pop; the i_ready path here is what sustains 1 word/cycle.
    assign demand       = 3'(occ) + 3'(inflight) - 3'(pop);
    assign o_fifo_rd_en = ~rst & ~i_fifo_empty & ~i_flush & (demand < 3'(BufDepth));

    // A read issued this cycle returns its word on the next cycle.
    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= o_fifo_rd_en;
        end
    end

    fifo_hold_buf #(
        .Width (Width)
    ) u_hold_buf (
        .clk       (clk_rd),
        .rst       (rst),
        .push      (land),
        .push_data (i_fifo_rd_data),
        .pop       (pop),
        .flush     (i_flush),
        .data      (o_data),
        .count     (occ)
    );

    assign o_valid = (occ != '0);
    assign o_level = occ;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomised checks of fifo_rd_stream against a queue-based stream model.
module tb_fifo_rd_stream;

    logic       clk_rd;
    logic       rst;
    logic       o_fifo_rd_en;
    logic       i_fifo_empty;
    logic [7:0] i_fifo_rd_data;
    logic       i_flush;
    logic       o_valid;
    logic [7:0] o_data;
    logic       i_ready;
    logic [1:0] o_level;

    fifo_rd_stream #(.Width(8), .BufDepth(2)) dut (
        .clk_rd         (clk_rd),
        .rst            (rst),
        .o_fifo_rd_en   (o_fifo_rd_en),
        .i_fifo_empty   (i_fifo_empty),
        .i_fifo_rd_data (i_fifo_rd_data),
        .i_flush        (i_flush),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .i_ready        (i_ready),
        .o_level        (o_level)
    );

    initial clk_rd = 1'b0;
    always #5 clk_rd = ~clk_rd;

    int checks = 0;
    int errors = 0;

    // Source FIFO contents, words held by the stage, word in flight, observed stream
    logic [7:0] src[$];
    logic [7:0] held[$];
    logic [7:0] inflight_q[$];
    logic [7:0] dut_out[$];
    logic [7:0] exp_q[$];
    logic [7:0] rnd_words[$];
    logic       rd_log[$];
    logic       v_log[$];
    logic [7:0] d_log[$];
    logic [1:0] l_log[$];

    logic       ready_v;
    logic       block_empty;
    logic       flush_v;
    logic       hold_prev;
    logic [7:0] prev_data;
    int         rd_cnt;
    int         guard;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag, input logic [7:0] e[$]);
        check({tag, "_count"}, 32'(dut_out.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < dut_out.size(); i++) begin
            check({tag, "_word"}, 32'(dut_out[i]), 32'(e[i]));
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        v_log.delete();
        d_log.delete();
        l_log.delete();
        dut_out.delete();
    endtask

    // One clock: apply inputs, check outputs mid-cycle, advance the model across the edge.
    task automatic tick();
        logic       exp_rd;
        logic       pop;
        logic [7:0] w;
        int         occ_i;
        w            = 8'h00;
        i_ready      = ready_v;
        i_flush      = flush_v;
        i_fifo_empty = block_empty || (src.size() == 0);
        @(negedge clk_rd);
        occ_i  = held.size();
        pop    = (occ_i != 0) && ready_v && !flush_v;
        exp_rd = !i_fifo_empty && !flush_v
                 && (occ_i + inflight_q.size() - (pop ? 1 : 0) < 2);
        check("rd_en", 32'(o_fifo_rd_en), 32'(exp_rd));
        check("valid", 32'(o_valid), 32'(occ_i != 0));
        check("level", 32'(o_level), 32'(occ_i));
        if (occ_i != 0) check("data", 32'(o_data), 32'(held[0]));
        if (hold_prev) check("stable", 32'(o_data), 32'(prev_data));
        hold_prev = o_valid && !i_ready && !flush_v;
        prev_data = o_data;
        rd_log.push_back(o_fifo_rd_en);
        v_log.push_back(o_valid);
        d_log.push_back(o_data);
        l_log.push_back(o_level);
        if (o_valid && i_ready && !flush_v) dut_out.push_back(o_data);
        if (flush_v) begin
            held.delete();
            inflight_q.delete();
        end else begin
            if (pop) void'(held.pop_front());
            if (inflight_q.size() != 0) held.push_back(inflight_q.pop_front());
        end
        if (exp_rd) begin
            w = src.pop_front();
            inflight_q.push_back(w);
        end
        @(posedge clk_rd);
        #1;
        i_fifo_rd_data = exp_rd ? w : 8'($urandom);
    endtask

    initial begin
        rst            = 1'b1;
        i_flush        = 1'b0;
        i_ready        = 1'b0;
        i_fifo_rd_data = 8'h00;
        i_fifo_empty   = 1'b0;
        ready_v        = 1'b0;
        block_empty    = 1'b0;
        flush_v        = 1'b0;
        hold_prev      = 1'b0;
        prev_data      = 8'h00;
        src            = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset held for 3 cycles with data available
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_rd);
            check("rst_rd_en", 32'(o_fifo_rd_en), 32'd0);
            check("rst_valid", 32'(o_valid), 32'd0);
            check("rst_level", 32'(o_level), 32'd0);
            check("rst_data", 32'(o_data), 32'd0);
        end
        @(posedge clk_rd);
        #1;
        rst = 1'b0;

        // Streaming at full rate
        clear_logs();
        ready_v = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 4; i++) check("t2_rd_run", 32'(rd_log[i]), 32'd1);
        check("t2_rd_stop", 32'(rd_log[4]), 32'd0);
        check("t2_lat_v1", 32'(v_log[1]), 32'd0);
        check("t2_lat_v2", 32'(v_log[2]), 32'd1);
        check("t2_d2", 32'(d_log[2]), 32'h11);
        check("t2_d5", 32'(d_log[5]), 32'h44);
        check("t2_v6", 32'(v_log[6]), 32'd0);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_stream("t2", exp_q);

        // Backpressure: buffer fills to 2 then one pop frees a slot
        clear_logs();
        src     = '{8'h11, 8'h22, 8'h33, 8'h44};
        ready_v = 1'b0;
        repeat (5) tick();
        rd_cnt = 0;
        foreach (rd_log[i]) rd_cnt += int'(rd_log[i]);
        check("t3_reads", 32'(rd_cnt), 32'd2);
        check("t3_level", 32'(o_level), 32'd2);
        check("t3_head", 32'(o_data), 32'h11);
        rd_log.delete();
        ready_v = 1'b1;
        tick();
        check("t3_reissue", 32'(rd_log[0]), 32'd1);
        ready_v = 1'b0;
        tick();
        check("t3_next", 32'(d_log[d_log.size() - 1]), 32'h22);
        ready_v = 1'b1;
        repeat (8) tick();
        check_stream("t3", exp_q);

        // Source runs dry after a single word
        clear_logs();
        src = '{8'h55};
        repeat (5) tick();
        rd_cnt = 0;
        foreach (rd_log[i]) rd_cnt += int'(rd_log[i]);
        check("t4_reads", 32'(rd_cnt), 32'd1);
        check("t4_v2", 32'(v_log[2]), 32'd1);
        check("t4_v3", 32'(v_log[3]), 32'd0);
        exp_q = '{8'h55};
        check_stream("t4", exp_q);

        // Flush with one word buffered and one landing
        clear_logs();
        src     = '{8'h66, 8'h77, 8'h88};
        ready_v = 1'b0;
        tick();
        tick();
        ready_v = 1'b1;
        flush_v = 1'b1;
        tick();
        flush_v = 1'b0;
        tick();
        repeat (5) tick();
        check("t5_pre_level", 32'(l_log[2]), 32'd1);
        check("t5_pre_data", 32'(d_log[2]), 32'h66);
        check("t5_post_valid", 32'(v_log[3]), 32'd0);
        check("t5_post_level", 32'(l_log[3]), 32'd0);
        exp_q = '{8'h88};
        check_stream("t5", exp_q);

        // Randomised backpressure and source starvation over 1000 words
        clear_logs();
        rnd_words.delete();
        for (int i = 0; i < 1000; i++) rnd_words.push_back(8'($urandom));
        src   = rnd_words;
        guard = 0;
        while (dut_out.size() < 1000 && guard < 20000) begin
            ready_v     = ($urandom_range(0, 3) != 0);
            block_empty = ($urandom_range(0, 4) == 0);
            tick();
            guard++;
        end
        block_empty = 1'b0;
        check_stream("t6", rnd_words);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
